layer4_fc_sequencer: RTL and testbench
======================================

Name: layer4_fc_sequencer

Overview:
Control and data feeder for the fully-connected layer (120 inputs to 84 outputs). It reads activations, weights and biases from on-chip memories and streams each neuron's 120 product pairs into the accumulating PE, which sums them, adds bias and applies ReLU. It then captures the PE result, writes it to the result buffer and re-arms the PE for the next neuron. It is the driving end of the PE's ena/din1/din2/bias/finish interface.

Parameters:
N_IN, 120, inputs per neuron; must equal the PE's hard-wired count
N_OUT, 84, neurons computed per start
DW, 16, data width, signed fixed-point, passed through unchanged
ACT_AW, 7, activation/result address width
W_AW, 14, weight address width (N_IN*N_OUT <= 2^W_AW)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a layer pass; sampled in IDLE only
busy  out  1  high from the cycle after start is accepted until DONE or abort
done  out  1  one-cycle pulse when all N_OUT results are written
err  out  1  sticky; set on missing pe_finish; cleared by reset or accepted start
act_addr  out  ACT_AW  activation read address; data returns next cycle
act_rdata  in  DW  activation read data
w_addr  out  W_AW  weight read address = neuron*N_IN + i; 1-cycle latency
w_rdata  in  DW  weight read data
b_addr  out  ACT_AW  bias read address = neuron; 1-cycle latency
b_rdata  in  DW  bias read data
pe_reset  out  1  active-high clear to PE; registered
pe_ena  out  1  PE accumulate enable; registered
pe_din1  out  DW  = act_rdata (combinational)
pe_din2  out  DW  = w_rdata (combinational)
pe_bias  out  DW  bias register, latched per neuron
pe_dout  in  DW  PE result
pe_finish  in  1  PE completion flag
res_we  out  1  result write strobe
res_addr  out  ACT_AW  result address = neuron
res_wdata  out  DW  captured pe_dout

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy, done, err, pe_ena, res_we = 0; pe_reset = 1; all addresses, pe_bias, res_wdata and counters = 0.
- IDLE: pe_reset = 1. start=1 -> CLR, neuron = 0, err cleared.
- CLR (1 cycle): pe_reset = 1; b_addr = neuron; issue index 0 is not yet issued.
- ISSUE (N_IN cycles, i = 0..N_IN-1): pe_reset = 0; act_addr = i, w_addr = neuron*N_IN + i. An address-valid flag is registered into pe_ena, so pe_ena is high exactly N_IN consecutive cycles, aligned with returning data. pe_bias latches b_rdata in the first ISSUE cycle.
- DRAIN (2 cycles): the last pe_ena is high in DRAIN cycle 1. pe_finish must be 1 in DRAIN cycle 2; capture res_wdata = pe_dout there and go to WRITE. If pe_finish = 0: set err, pe_reset = 1, go to IDLE with busy = 0 and no done.
- WRITE (1 cycle): res_we = 1, res_addr = neuron. If neuron = N_OUT-1, go to DONE; else neuron+1 and go to CLR, which clears the PE accumulator and count.
- DONE (1 cycle): done = 1, pe_reset = 1, then IDLE.
- Per-neuron time is N_IN+4 cycles. done is asserted at start edge + 1 + N_OUT*(N_IN+4) (= 10417 with defaults).
- pe_ena never has gaps within a neuron. There is no backpressure, and memories are always ready.
- start while busy is ignored. start held high through DONE starts a new pass from IDLE.
- Reset mid-operation aborts immediately: no res_we, and the PE is held cleared by pe_reset.
- Address arithmetic is unsigned. The weight base accumulates +N_IN per neuron, with no multiplier.

Decomposition:
- Shared package or header holds the state encoding (IDLE, CLR, ISSUE, DRAIN, WRITE, DONE) and the layer constants N_IN=120, N_OUT=84, DW=16, used by both the PE and this block.
- No sub-module: one FSM plus index/neuron/weight-base counters. The PE instance sits alongside in the layer top.

Test Plan:
- All act=1, w=1, bias=0 -> 84 writes of 120, at addresses 0..83; done at start+10417; each pe_ena run is exactly 120 cycles.
- act=1, w=-1, bias=5 -> every result 0 (ReLU); err=0.
- act[i]=1; neuron j weights 1 for i<j, else 0; bias=2 -> res[j]=j+2, checks w_addr base stepping of 120.
- start pulsed again at cycle 500 -> ignored, results unchanged. start held high -> second pass begins the cycle after done.
- reset low during ISSUE of neuron 3 -> outputs at reset values within the same cycle, no further res_we; a fresh start then gives correct results 0..83.
- PE model suppresses pe_finish for neuron 5 -> err=1, busy falls, done never pulses, only results 0..4 written.

Source files
------------

// File: rtl/layer4_fc_sequencer_pkg.sv
// Shared constants and state encoding for the FC layer (120 -> 84) sequencer and its PE.
package layer4_fc_sequencer_pkg;

  localparam int unsigned N_IN   = 120;  // inputs per neuron, matches the PE's fixed count
  localparam int unsigned N_OUT  = 84;   // neurons per layer pass
  localparam int unsigned DW     = 16;   // signed fixed-point data width
  localparam int unsigned ACT_AW = 7;    // activation / bias / result address width
  localparam int unsigned W_AW   = 14;   // weight address width

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StIssue,
    StDrain,
    StWrite,
    StDone
  } fc_state_e;

endpackage

// File: rtl/layer4_fc_sequencer.sv
// Sequencer for the fully-connected layer: streams activation/weight pairs of each neuron into the
// accumulating PE, captures the PE result and writes it to the result buffer.
module layer4_fc_sequencer
  import layer4_fc_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ACT_AW-1:0] act_addr,
  input  logic [DW-1:0]     act_rdata,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DW-1:0]     w_rdata,
  output logic [ACT_AW-1:0] b_addr,
  input  logic [DW-1:0]     b_rdata,
  output logic              pe_reset,
  output logic              pe_ena,
  output logic [DW-1:0]     pe_din1,
  output logic [DW-1:0]     pe_din2,
  output logic [DW-1:0]     pe_bias,
  input  logic [DW-1:0]     pe_dout,
  input  logic              pe_finish,
  output logic              res_we,
  output logic [ACT_AW-1:0] res_addr,
  output logic [DW-1:0]     res_wdata
);

  localparam logic [ACT_AW-1:0] LastIdx    = ACT_AW'(N_IN - 1);
  localparam logic [ACT_AW-1:0] LastNeuron = ACT_AW'(N_OUT - 1);
  localparam logic [W_AW-1:0]   WStep      = W_AW'(N_IN);

  fc_state_e         state_q, state_d;
  logic [ACT_AW-1:0] idx_q, idx_d;        // input index within the current neuron
  logic [ACT_AW-1:0] neuron_q, neuron_d;
  logic [W_AW-1:0]   wbase_q, wbase_d;    // neuron * N_IN, built by repeated addition
  logic              drain_q, drain_d;    // second DRAIN cycle
  logic              err_q, err_d;
  logic              pe_reset_q, pe_reset_d;
  logic              pe_ena_q, pe_ena_d;
  logic [DW-1:0]     bias_q, bias_d;
  logic [DW-1:0]     res_q, res_d;

  // Next-state, counters and captured data.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    neuron_d = neuron_q;
    wbase_d  = wbase_q;
    drain_d  = drain_q;
    err_d    = err_q;
    bias_d   = bias_q;
    res_d    = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StClr;
          neuron_d = '0;
          wbase_d  = '0;
          err_d    = 1'b0;
        end
      end
      StClr: begin
        state_d = StIssue;
        idx_d   = '0;
      end
      StIssue: begin
        // Bias was addressed during CLR, so its data is on b_rdata now.
        if (idx_q == '0) bias_d = b_rdata;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          drain_d = 1'b0;
          state_d = StDrain;
        end else begin
          idx_d = idx_q + ACT_AW'(1);
        end
      end
      StDrain: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
          if (pe_finish) begin
            res_d   = pe_dout;
            state_d = StWrite;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWrite: begin
        if (neuron_q == LastNeuron) begin
          state_d = StDone;
        end else begin
          neuron_d = neuron_q + ACT_AW'(1);
          wbase_d  = wbase_q + WStep;
          state_d  = StClr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // pe_ena trails the address by one cycle so it lines up with the returning read data.
    pe_ena_d   = (state_q == StIssue);
    pe_reset_d = state_d inside {StIdle, StClr, StDone};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      neuron_q   <= '0;
      wbase_q    <= '0;
      drain_q    <= 1'b0;
      err_q      <= 1'b0;
      pe_reset_q <= 1'b1;
      pe_ena_q   <= 1'b0;
      bias_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      neuron_q   <= neuron_d;
      wbase_q    <= wbase_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      pe_reset_q <= pe_reset_d;
      pe_ena_q   <= pe_ena_d;
      bias_q     <= bias_d;
      res_q      <= res_d;
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign act_addr  = idx_q;
  assign w_addr    = wbase_q + W_AW'(idx_q);
  assign b_addr    = neuron_q;
  assign pe_reset  = pe_reset_q;
  assign pe_ena    = pe_ena_q;
  assign pe_din1   = act_rdata;
  assign pe_din2   = w_rdata;
  assign pe_bias   = bias_q;
  assign res_we    = (state_q == StWrite);
  assign res_addr  = neuron_q;
  assign res_wdata = res_q;

endmodule

// File: tb/tb_layer4_fc_sequencer.sv
// Bench for layer4_fc_sequencer: memory and PE models around the DUT, a per-layer expected-result
// model computed from the memory contents, and one compare process watching writes, pe_ena runs
// and done timing.
module tb_layer4_fc_sequencer;
  import layer4_fc_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, err;
  logic [ACT_AW-1:0] act_addr, b_addr, res_addr;
  logic [W_AW-1:0]   w_addr;
  logic [DW-1:0]     act_rdata = '0, w_rdata = '0, b_rdata = '0;
  logic              pe_reset, pe_ena, pe_finish, res_we;
  logic [DW-1:0]     pe_din1, pe_din2, pe_bias, pe_dout, res_wdata;

  always #5 clk = ~clk;

  layer4_fc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .act_addr  (act_addr),
    .act_rdata (act_rdata),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .b_addr    (b_addr),
    .b_rdata   (b_rdata),
    .pe_reset  (pe_reset),
    .pe_ena    (pe_ena),
    .pe_din1   (pe_din1),
    .pe_din2   (pe_din2),
    .pe_bias   (pe_bias),
    .pe_dout   (pe_dout),
    .pe_finish (pe_finish),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_wdata (res_wdata)
  );

  // Synchronous-read memories, one cycle latency.
  logic signed [DW-1:0] act_mem [0:127];
  logic signed [DW-1:0] w_mem   [0:16383];
  logic signed [DW-1:0] b_mem   [0:127];

  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    w_rdata   <= w_mem[w_addr];
    b_rdata   <= b_mem[b_addr];
  end

  // Accumulating PE: sums N_IN products, adds bias, ReLU; finish can be withheld for one neuron.
  int pe_acc = 0;
  int pe_cnt = 0;
  int suppress_neuron = -1;

  function automatic logic [DW-1:0] relu16(input int v);
    return (v < 0) ? 16'd0 : v[15:0];
  endfunction

  always @(posedge clk) begin
    if (pe_reset) begin
      pe_acc <= 0;
      pe_cnt <= 0;
    end else if (pe_ena) begin
      pe_acc <= pe_acc + int'($signed(pe_din1)) * int'($signed(pe_din2));
      pe_cnt <= pe_cnt + 1;
    end
  end

  assign pe_dout   = relu16(pe_acc + int'($signed(pe_bias)));
  assign pe_finish = (pe_cnt == int'(N_IN)) && (int'(b_addr) != suppress_neuron);

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected layer output straight from the memory contents.
  int exp_res [0:127];

  task automatic build_expected();
    for (int j = 0; j < 128; j++) exp_res[j] = 0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      int s;
      s = int'(b_mem[j]);
      for (int i = 0; i < int'(N_IN); i++) s += int'(act_mem[i]) * int'(w_mem[j * int'(N_IN) + i]);
      exp_res[j] = (s < 0) ? 0 : s;
    end
  endtask

  // mode 0: act=1 w=1 b=0; mode 1: act=1 w=-1 b=5; mode 2: act=1, w[j][i]=(i<j), b=2
  task automatic load_mem(input int mode);
    for (int i = 0; i < 128; i++) begin
      act_mem[i] = 16'sd1;
      b_mem[i]   = (mode == 0) ? 16'sd0 : (mode == 1) ? 16'sd5 : 16'sd2;
    end
    for (int j = 0; j < int'(N_OUT); j++) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (mode == 0)      w_mem[j * int'(N_IN) + i] = 16'sd1;
        else if (mode == 1) w_mem[j * int'(N_IN) + i] = -16'sd1;
        else                w_mem[j * int'(N_IN) + i] = (i < j) ? 16'sd1 : 16'sd0;
      end
    end
  endtask

  // Compare-process state (expected next write address, done timing, pe_ena run length).
  int exp_next = 0;
  int exp_done_cyc = 0;
  bit done_armed = 1'b0;
  int run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      run = 0;
    end else begin
      if (res_we) begin
        check("res_addr", int'(res_addr), exp_next);
        check("res_wdata", int'(res_wdata), exp_res[res_addr]);
        exp_next++;
      end
      if (pe_ena) begin
        run++;
      end else if (run != 0) begin
        check("pe_ena_run", run, int'(N_IN));
        run = 0;
      end
      if (done || (done_armed && cyc == exp_done_cyc)) begin
        check("done_cycle", done ? cyc : -1, done_armed ? exp_done_cyc : -2);
        done_armed = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pass(input bit hold);
    build_expected();
    exp_next     = 0;
    start        = 1'b1;
    exp_done_cyc = cyc + 1 + int'(N_OUT) * (int'(N_IN) + 4);
    done_armed   = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_armed && n < 11000) begin
      tick();
      n++;
    end
    check("done_timeout", int'(done_armed), 0);
  endtask

  int d_cyc;
  int n;
  int s_cyc;

  initial begin
    for (int i = 0; i < 16384; i++) w_mem[i] = 16'sd0;
    load_mem(0);
    tick(2);

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_pe_ena", int'(pe_ena), 0);
    check("rst_res_we", int'(res_we), 0);
    check("rst_pe_reset", int'(pe_reset), 1);
    check("rst_act_addr", int'(act_addr), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_pe_bias", int'(pe_bias), 0);
    check("rst_res_wdata", int'(res_wdata), 0);
    reset = 1'b1;
    tick();

    // Pass 1: all ones, start held high for the whole pass
    build_expected();
    check("model_m0_n0", exp_res[0], 120);
    check("model_m0_n83", exp_res[83], 120);
    start_pass(1'b1);
    check("clr_busy", int'(busy), 1);
    check("clr_pe_reset", int'(pe_reset), 1);
    check("clr_b_addr", int'(b_addr), 0);
    tick();
    check("issue0_pe_reset", int'(pe_reset), 0);
    check("issue0_act_addr", int'(act_addr), 0);
    check("issue0_pe_ena", int'(pe_ena), 0);
    tick();
    check("issue1_act_addr", int'(act_addr), 1);
    check("issue1_w_addr", int'(w_addr), 1);
    check("issue1_pe_ena", int'(pe_ena), 1);
    check("issue1_pe_din1", int'(pe_din1), 1);
    wait_done();
    check("m0_write_count", exp_next, 84);
    check("m0_err", int'(err), 0);

    // Held start re-arms from IDLE right after DONE
    d_cyc    = exp_done_cyc;
    exp_next = 0;
    while (cyc < d_cyc + 1) tick();
    check("idle_after_done_busy", int'(busy), 0);
    tick();
    check("restart_busy", int'(busy), 1);
    start = 1'b0;

    // Abort with reset during ISSUE of neuron 3
    n = 0;
    while (!(b_addr == 3 && pe_ena) && n < 1000) begin
      tick();
      n++;
    end
    check("reach_neuron3", int'(n < 1000), 1);
    check("writes_before_abort", exp_next, 3);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_pe_ena", int'(pe_ena), 0);
    check("abort_pe_reset", int'(pe_reset), 1);
    check("abort_res_we", int'(res_we), 0);
    check("abort_w_addr", int'(w_addr), 0);
    check("abort_b_addr", int'(b_addr), 0);
    tick(5);
    reset = 1'b1;
    tick(3);
    check("abort_no_writes", exp_next, 3);

    // Staircase weights: checks the per-neuron weight base; a stray start mid-pass is ignored
    load_mem(2);
    build_expected();
    check("model_m2_n0", exp_res[0], 2);
    check("model_m2_n5", exp_res[5], 7);
    check("model_m2_n83", exp_res[83], 85);
    s_cyc = cyc;
    start_pass(1'b0);
    while (cyc < s_cyc + 500) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("m2_write_count", exp_next, 84);

    // Negative sums clamp to zero
    load_mem(1);
    build_expected();
    check("model_m1_n10", exp_res[10], 0);
    start_pass(1'b0);
    wait_done();
    check("m1_write_count", exp_next, 84);
    check("m1_err", int'(err), 0);

    // Missing pe_finish on neuron 5
    load_mem(0);
    suppress_neuron = 5;
    build_expected();
    exp_next   = 0;
    done_armed = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 1500) begin
      tick();
      n++;
    end
    check("err_busy_fall", int'(busy), 0);
    check("err_set", int'(err), 1);
    check("err_pe_reset", int'(pe_reset), 1);
    check("err_writes", exp_next, 5);
    tick(20);
    check("err_err_sticky", int'(err), 1);
    check("err_no_more_writes", exp_next, 5);
    suppress_neuron = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cleared_by_start", int'(err), 0);
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
